// File: rtl/frame_render_scheduler_if.sv
// Handshake bundle between the frame render scheduler, the VGA timing
// generator and the render engine. The slave modport is the scheduler's
// view; the master modport is the view of whatever drives it.
interface frame_render_scheduler_if;
    logic enable;
    logic endframe;
    logic newframe;
    logic render_done;
    logic render_start;
    logic render_abort;
    logic render_busy;
    logic front_buf;
    logic back_buf;
    logic swap;
    logic overrun;

    modport master (
        output enable, endframe, newframe, render_done,
        input  render_start, render_abort, render_busy,
               front_buf, back_buf, swap, overrun
    );

    modport slave (
        input  enable, endframe, newframe, render_done,
        output render_start, render_abort, render_busy,
               front_buf, back_buf, swap, overrun
    );
endinterface

// File: rtl/frame_render_scheduler.sv
// Per-frame sequencer between the 640x480 VGA timing generator and the
// render engine. Starts a render at each endframe, polices the render
// deadline and owns the front/back framebuffer select so that scanout
// only ever changes buffers during vblank.
//
// Optional feature: define STATS_EN to get a wrapping frame counter and a
// saturating overrun counter. Without it both count ports are tied to 0
// and no counter flops exist.
module frame_render_scheduler #(
    parameter int DOUBLE_BUF  = 1,
    parameter int FRAME_CNT_W = 16,
    parameter int OVR_CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    frame_render_scheduler_if.slave bus,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [OVR_CNT_W-1:0]   overrun_cnt
);

    localparam bit DB = (DOUBLE_BUF != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RENDER = 2'd2,
        READY  = 2'd3
    } state_t;

    state_t state;

    logic deadline;
    logic done_evt;
    logic ovr_evt;
    logic swap_evt;

    // Decode this cycle's events: done only counts while rendering, a
    // deadline without done is an overrun, and a swap happens at endframe
    // either from READY or when done arrives together with the endframe.
    always_comb begin
        deadline = DB ? bus.endframe : bus.newframe;
        done_evt = (state == RENDER) && bus.render_done;
        ovr_evt  = (state == RENDER) && !bus.render_done && deadline;
        swap_evt = DB && bus.endframe && ((state == READY) || done_evt);
    end

    // Scanout reads the front buffer; the renderer writes the other one,
    // or the same one when running single-buffered.
    assign bus.back_buf = DB ? ~bus.front_buf : bus.front_buf;

    // Scheduler state machine with all outputs registered, so every pulse
    // lands one cycle after the input that caused it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bus.render_start <= 1'b0;
            bus.render_abort <= 1'b0;
            bus.render_busy  <= 1'b0;
            bus.front_buf    <= 1'b0;
            bus.swap         <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            bus.render_start <= 1'b0;
            bus.render_abort <= 1'b0;
            bus.swap         <= 1'b0;
            bus.overrun      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable)
                        state <= ARMED;
                end
                ARMED: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                    end else if (bus.endframe) begin
                        bus.render_start <= 1'b1;
                        bus.render_busy  <= 1'b1;
                        state            <= RENDER;
                    end
                end
                RENDER: begin
                    if (bus.render_done) begin
                        bus.render_busy <= 1'b0;
                        if (!DB) begin
                            state <= ARMED;
                        end else if (swap_evt) begin
                            bus.front_buf <= ~bus.front_buf;
                            bus.swap      <= 1'b1;
                            if (bus.enable) begin
                                bus.render_start <= 1'b1;
                                bus.render_busy  <= 1'b1;
                                state            <= RENDER;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            state <= READY;
                        end
                    end else if (ovr_evt) begin
                        bus.overrun <= 1'b1;
                        if (!DB) begin
                            bus.render_abort <= 1'b1;
                            bus.render_busy  <= 1'b0;
                            state            <= ARMED;
                        end
                    end
                end
                READY: begin
                    if (bus.endframe) begin
                        bus.front_buf <= ~bus.front_buf;
                        bus.swap      <= 1'b1;
                        if (bus.enable) begin
                            bus.render_start <= 1'b1;
                            bus.render_busy  <= 1'b1;
                            state            <= RENDER;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STATS_EN
    logic frame_evt;

    assign frame_evt = DB ? swap_evt : done_evt;

    // Frame counter wraps; the overrun counter sticks at all-ones so a
    // long-running overload is still visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            if (frame_evt)
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            if (ovr_evt && (overrun_cnt != {OVR_CNT_W{1'b1}}))
                overrun_cnt <= overrun_cnt + OVR_CNT_W'(1);
        end
    end
`else
    assign frame_cnt   = '0;
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_render_scheduler.sv
// Directed bench for frame_render_scheduler. One instance runs
// double-buffered, one single-buffered; both see the same stimulus and
// each scenario checks the instance it is aimed at. Expected counter
// values follow whether STATS_EN is defined for the build.
module tb_frame_render_scheduler;

`ifdef STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic ef = 1'b0;
    logic nf = 1'b0;
    logic done = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] db_frame_cnt;
    logic [7:0]  db_overrun_cnt;
    logic [15:0] sb_frame_cnt;
    logic [7:0]  sb_overrun_cnt;

    frame_render_scheduler_if dbus ();
    frame_render_scheduler_if sbus ();

    assign dbus.enable      = enable;
    assign dbus.endframe    = ef;
    assign dbus.newframe    = nf;
    assign dbus.render_done = done;
    assign sbus.enable      = enable;
    assign sbus.endframe    = ef;
    assign sbus.newframe    = nf;
    assign sbus.render_done = done;

    frame_render_scheduler #(.DOUBLE_BUF(1), .FRAME_CNT_W(16), .OVR_CNT_W(8)) u_db (
        .clk         (clk),
        .reset       (reset),
        .bus         (dbus.slave),
        .frame_cnt   (db_frame_cnt),
        .overrun_cnt (db_overrun_cnt)
    );

    frame_render_scheduler #(.DOUBLE_BUF(0), .FRAME_CNT_W(16), .OVR_CNT_W(8)) u_sb (
        .clk         (clk),
        .reset       (reset),
        .bus         (sbus.slave),
        .frame_cnt   (sb_frame_cnt),
        .overrun_cnt (sb_overrun_cnt)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Hold the given pulses for exactly one clock, then release them.
    task automatic applyStimulus(input bit e, input bit n, input bit d);
        ef   = e;
        nf   = n;
        done = d;
        tick();
        ef   = 1'b0;
        nf   = 1'b0;
        done = 1'b0;
    endtask

    task automatic doReset();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Main directed sequence.
    initial begin
        doReset();
        checkOutput("rst_start",   32'(dbus.render_start), 0);
        checkOutput("rst_busy",    32'(dbus.render_busy), 0);
        checkOutput("rst_front",   32'(dbus.front_buf), 0);
        checkOutput("rst_back_db", 32'(dbus.back_buf), 1);
        checkOutput("rst_back_sb", 32'(sbus.back_buf), 0);
        checkOutput("rst_swap",    32'(dbus.swap), 0);
        checkOutput("rst_overrun", 32'(dbus.overrun), 0);
        checkOutput("rst_fcnt",    32'(db_frame_cnt), 0);

        // Normal double-buffered frame: start, done, swap with restart.
        enable = 1'b1;
        tick();
        applyStimulus(1, 0, 0);
        checkOutput("s1_start", 32'(dbus.render_start), 1);
        checkOutput("s1_busy",  32'(dbus.render_busy), 1);
        repeat (98) tick();
        applyStimulus(0, 0, 1);
        checkOutput("s1_done_busy", 32'(dbus.render_busy), 0);
        checkOutput("s1_done_swap", 32'(dbus.swap), 0);
        repeat (5) tick();
        applyStimulus(1, 0, 0);
        checkOutput("s1_swap",    32'(dbus.swap), 1);
        checkOutput("s1_front",   32'(dbus.front_buf), 1);
        checkOutput("s1_back",    32'(dbus.back_buf), 0);
        checkOutput("s1_restart", 32'(dbus.render_start), 1);
        tick();
        checkOutput("s1_swap_pulse", 32'(dbus.swap), 0);
        checkOutput("s1_fcnt", 32'(db_frame_cnt), STATS_ON ? 1 : 0);

        // Missed deadline: overrun only, the late frame swaps afterwards.
        applyStimulus(1, 0, 0);
        checkOutput("s2_overrun", 32'(dbus.overrun), 1);
        checkOutput("s2_noswap",  32'(dbus.swap), 0);
        checkOutput("s2_busy",    32'(dbus.render_busy), 1);
        checkOutput("s2_front",   32'(dbus.front_buf), 1);
        applyStimulus(0, 0, 1);
        checkOutput("s2_done_busy", 32'(dbus.render_busy), 0);
        applyStimulus(1, 0, 0);
        checkOutput("s2_swap",    32'(dbus.swap), 1);
        checkOutput("s2_front2",  32'(dbus.front_buf), 0);
        checkOutput("s2_no_ovr",  32'(dbus.overrun), 0);
        checkOutput("s2_ocnt",    32'(db_overrun_cnt), STATS_ON ? 1 : 0);

        // Done and endframe together: done wins, swap and restart at once.
        applyStimulus(1, 0, 1);
        checkOutput("s4_no_ovr", 32'(dbus.overrun), 0);
        checkOutput("s4_swap",   32'(dbus.swap), 1);
        checkOutput("s4_start",  32'(dbus.render_start), 1);
        checkOutput("s4_front",  32'(dbus.front_buf), 1);
        checkOutput("s4_fcnt",   32'(db_frame_cnt), STATS_ON ? 3 : 0);

        // Enable dropped mid-render: finish, swap, then go idle.
        enable = 1'b0;
        applyStimulus(0, 0, 1);
        checkOutput("s5_busy", 32'(dbus.render_busy), 0);
        applyStimulus(1, 0, 0);
        checkOutput("s5_swap",    32'(dbus.swap), 1);
        checkOutput("s5_nostart", 32'(dbus.render_start), 0);
        checkOutput("s5_front",   32'(dbus.front_buf), 0);
        applyStimulus(1, 0, 0);
        checkOutput("s5_idle_start", 32'(dbus.render_start), 0);
        checkOutput("s5_idle_swap",  32'(dbus.swap), 0);
        checkOutput("s5_fcnt", 32'(db_frame_cnt), STATS_ON ? 4 : 0);

        // Reset while a render is in flight.
        enable = 1'b1;
        tick();
        applyStimulus(1, 0, 0);
        checkOutput("s5_rstart", 32'(dbus.render_start), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("s5_rst_busy",  32'(dbus.render_busy), 0);
        checkOutput("s5_rst_abort", 32'(dbus.render_abort), 0);
        checkOutput("s5_rst_front", 32'(dbus.front_buf), 0);
        checkOutput("s5_rst_fcnt",  32'(db_frame_cnt), 0);

        // Single buffer: newframe without done aborts the render.
        doReset();
        enable = 1'b1;
        tick();
        applyStimulus(1, 0, 0);
        checkOutput("s3_start", 32'(sbus.render_start), 1);
        checkOutput("s3_back",  32'(sbus.back_buf), 0);
        repeat (50) tick();
        applyStimulus(0, 1, 0);
        checkOutput("s3_abort",   32'(sbus.render_abort), 1);
        checkOutput("s3_overrun", 32'(sbus.overrun), 1);
        checkOutput("s3_busy",    32'(sbus.render_busy), 0);
        checkOutput("s3_db_ovr",  32'(dbus.overrun), 0);
        tick();
        checkOutput("s3_abort_pulse", 32'(sbus.render_abort), 0);
        applyStimulus(0, 0, 1);
        checkOutput("s3_stray_done", 32'(sbus.render_start), 0);
        applyStimulus(1, 0, 0);
        checkOutput("s3_restart", 32'(sbus.render_start), 1);
        applyStimulus(0, 0, 1);
        checkOutput("s3_done_busy", 32'(sbus.render_busy), 0);
        checkOutput("s3_noswap",    32'(sbus.swap), 0);
        checkOutput("s3_fcnt", 32'(sb_frame_cnt), STATS_ON ? 1 : 0);
        checkOutput("s3_ocnt", 32'(sb_overrun_cnt), STATS_ON ? 1 : 0);
        applyStimulus(0, 1, 0);
        checkOutput("s3_armed_nf", 32'(sbus.overrun), 0);

        // Many consecutive overruns saturate the overrun counter.
        doReset();
        enable = 1'b1;
        tick();
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 300; i++)
            applyStimulus(1, 0, 0);
        checkOutput("s6_overrun", 32'(dbus.overrun), 1);
        checkOutput("s6_busy",    32'(dbus.render_busy), 1);
        checkOutput("s6_ocnt",    32'(db_overrun_cnt), STATS_ON ? 255 : 0);
        checkOutput("s6_fcnt",    32'(db_frame_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
